// File: rtl/cfg_pkg.sv
// ---------------------------------------------------------------------------
// cfg_pkg
// Shared definitions for the configuration packet parser: FSM state encoding,
// the default sync marker, packet geometry and well-known register addresses.
// ---------------------------------------------------------------------------
package cfg_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      DATA,
      CSUM
   } state_t;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   // Bytes that follow the sync marker: address, data payload, checksum.
   localparam int PKT_LEN    = 6;
   localparam int DATA_BYTES = PKT_LEN - 2;

   localparam logic [7:0] REG_CONFIG = 8'd0;

endpackage : cfg_pkg

// File: rtl/sat_counter8.sv
// ---------------------------------------------------------------------------
// sat_counter8
// 8-bit event counter that sticks at 255 instead of wrapping.
//   clk    in   system clock
//   rst    in   synchronous active-high reset (count -> 0)
//   clr    in   synchronous clear (count -> 0)
//   inc    in   count one event this cycle
//   count  out  current count, 0..255
// ---------------------------------------------------------------------------
module sat_counter8 (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       inc,
   output logic [7:0] count
);

   // NOTE: sequential state is always assigned with <= so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= 8'd0;
      end else if (inc && (count != 8'hFF)) begin
         count <= count + 8'd1;
      end
   end

endmodule : sat_counter8

// File: rtl/cfg_packet_parser.sv
// ---------------------------------------------------------------------------
// cfg_packet_parser
// Frames the SPI received-byte stream into fixed write packets
//   SYNC, ADDR, D3, D2, D1, D0, CSUM   (CSUM = ADDR ^ D3 ^ D2 ^ D1 ^ D0)
// and issues a one-cycle register write for every valid packet. Register 0
// is mirrored on config_out. Accepted and rejected packets are counted with
// saturating counters for debug readback. An inter-byte gap of TIMEOUT idle
// cycles inside a packet aborts it and counts as an error.
//   clk            in   system clock
//   rst            in   synchronous active-high reset
//   byte_in        in   received byte
//   byte_valid     in   one-cycle strobe qualifying byte_in
//   cfg_wr_en      out  one-cycle write pulse for an accepted packet
//   cfg_wr_addr    out  write address (held between writes)
//   cfg_wr_data    out  write data (held between writes)
//   config_out     out  shadow of register 0
//   busy           out  high whenever a packet is in progress
//   pkt_ok_count   out  accepted packets, saturating at 255
//   pkt_err_count  out  rejected or timed-out packets, saturating at 255
// ---------------------------------------------------------------------------
module cfg_packet_parser
   import cfg_pkg::*;
#(
   parameter int          NUM_REGS  = 4,
   parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT,
   parameter int          TIMEOUT   = 1023,
   parameter logic [31:0] CFG_RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        cfg_wr_en,
   output logic [7:0]  cfg_wr_addr,
   output logic [31:0] cfg_wr_data,
   output logic [31:0] config_out,
   output logic        busy,
   output logic [7:0]  pkt_ok_count,
   output logic [7:0]  pkt_err_count
);

   localparam int TW = $clog2(TIMEOUT + 1);

   state_t      state;
   logic [7:0]  addr_q;
   logic [7:0]  csum_q;
   logic [31:0] data_q;
   logic [1:0]  idx_q;
   logic [TW-1:0] idle_cnt;

   logic timeout_hit;
   logic csum_byte;
   logic addr_ok;
   logic pkt_ok;
   logic pkt_err;

   // The idle counter would reach TIMEOUT on this edge. A byte arriving in
   // the same cycle takes priority, hence the !byte_valid term.
   assign timeout_hit = (state != IDLE) && !byte_valid &&
                        (idle_cnt == TW'(TIMEOUT - 1));

   assign csum_byte = (state == CSUM) && byte_valid;
   assign addr_ok   = int'(addr_q) < NUM_REGS;
   assign pkt_ok    = csum_byte && (byte_in == csum_q) && addr_ok;
   assign pkt_err   = (csum_byte && !((byte_in == csum_q) && addr_ok)) ||
                      timeout_hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         cfg_wr_en   <= 1'b0;
         cfg_wr_addr <= 8'd0;
         cfg_wr_data <= 32'd0;
         config_out  <= CFG_RESET;
         idle_cnt    <= '0;
         // NOTE: the packet assembly registers are reset as well; they are a
         // handful of flops, and it keeps the write bus deterministic.
         addr_q      <= 8'd0;
         csum_q      <= 8'd0;
         data_q      <= 32'd0;
         idx_q       <= 2'd0;
      end else begin
         // Write strobe defaults low so it can only ever last one cycle.
         cfg_wr_en <= 1'b0;

         if ((state == IDLE) || byte_valid || timeout_hit) begin
            idle_cnt <= '0;
         end else begin
            idle_cnt <= idle_cnt + TW'(1);
         end

         if (timeout_hit) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else if (byte_valid) begin
            case (state)
               IDLE: begin
                  // Non-sync bytes between packets are dropped silently.
                  if (byte_in == SYNC_BYTE) begin
                     state <= ADDR;
                     busy  <= 1'b1;
                  end
               end
               ADDR: begin
                  addr_q <= byte_in;
                  csum_q <= byte_in;
                  idx_q  <= 2'd0;
                  state  <= DATA;
               end
               DATA: begin
                  // MSB-first: the first data byte ends up in [31:24].
                  data_q <= {data_q[23:0], byte_in};
                  csum_q <= csum_q ^ byte_in;
                  idx_q  <= idx_q + 2'd1;
                  if (idx_q == 2'(DATA_BYTES - 1)) begin
                     state <= CSUM;
                  end
               end
               CSUM: begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (pkt_ok) begin
                     cfg_wr_en   <= 1'b1;
                     cfg_wr_addr <= addr_q;
                     cfg_wr_data <= data_q;
                     if (addr_q == REG_CONFIG) begin
                        config_out <= data_q;
                     end
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   sat_counter8 u_ok_count (
      .clk   (clk),
      .rst   (rst),
      .clr   (1'b0),
      .inc   (pkt_ok),
      .count (pkt_ok_count)
   );

   sat_counter8 u_err_count (
      .clk   (clk),
      .rst   (rst),
      .clr   (1'b0),
      .inc   (pkt_err),
      .count (pkt_err_count)
   );

endmodule : cfg_packet_parser

// File: tb/tb_cfg_packet_parser.sv
// ---------------------------------------------------------------------------
// tb_cfg_packet_parser
// Randomised and directed packet stimulus. The stimulus side knows each
// packet it sends, decides from the packet rules whether it must be accepted
// and pushes the expected write into a queue; a separate monitor pops and
// compares whenever the DUT raises cfg_wr_en. Counters, config_out and busy
// are compared against the bench's own packet-level model after each packet.
// ---------------------------------------------------------------------------
module tb_cfg_packet_parser;
   import cfg_pkg::*;

   localparam int          NUM_REGS  = 4;
   localparam int          TIMEOUT   = 1023;
   localparam logic [31:0] CFG_RESET = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        cfg_wr_en;
   logic [7:0]  cfg_wr_addr;
   logic [31:0] cfg_wr_data;
   logic [31:0] config_out;
   logic        busy;
   logic [7:0]  pkt_ok_count;
   logic [7:0]  pkt_err_count;

   cfg_packet_parser #(
      .NUM_REGS  (NUM_REGS),
      .SYNC_BYTE (8'hA5),
      .TIMEOUT   (TIMEOUT),
      .CFG_RESET (CFG_RESET)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .byte_in       (byte_in),
      .byte_valid    (byte_valid),
      .cfg_wr_en     (cfg_wr_en),
      .cfg_wr_addr   (cfg_wr_addr),
      .cfg_wr_data   (cfg_wr_data),
      .config_out    (config_out),
      .busy          (busy),
      .pkt_ok_count  (pkt_ok_count),
      .pkt_err_count (pkt_err_count)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
      int unsigned cyc;
   } wr_t;

   wr_t exp_q[$];

   int errors = 0;
   int checks = 0;

   // Packet-level reference model.
   int          m_ok  = 0;
   int          m_err = 0;
   logic [31:0] m_cfg = CFG_RESET;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] xor_sum(input logic [7:0] a,
                                          input logic [31:0] d);
      return a ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
   endfunction

   function automatic int sat_inc(input int v);
      return (v < 255) ? v + 1 : 255;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic gap(input int n);
      repeat (n) tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      byte_in    = b;
      byte_valid = 1'b1;
      tick();
      byte_valid = 1'b0;
   endtask

   task automatic check_model(input string tag);
      check({tag, "_ok_count"},  32'(pkt_ok_count),  32'(m_ok));
      check({tag, "_err_count"}, 32'(pkt_err_count), 32'(m_err));
      check({tag, "_config"},    config_out,         m_cfg);
      check({tag, "_busy"},      32'(busy),          32'd0);
   endtask

   // Sends a full packet; hold_idx/hold_len force a long gap before one byte.
   task automatic send_pkt(input logic [7:0] a, input logic [31:0] d,
                           input logic [7:0] cs, input int maxgap,
                           input int hold_idx, input int hold_len,
                           input string tag);
      logic [7:0] pkt [7];
      pkt[0] = 8'hA5;
      pkt[1] = a;
      pkt[2] = d[31:24];
      pkt[3] = d[23:16];
      pkt[4] = d[15:8];
      pkt[5] = d[7:0];
      pkt[6] = cs;
      for (int i = 0; i < 7; i++) begin
         if (i == hold_idx)  gap(hold_len);
         else if (i > 0)     gap(int'($urandom_range(0, maxgap)));
         send_byte(pkt[i]);
      end
      if ((cs == xor_sum(a, d)) && (int'(a) < NUM_REGS)) begin
         exp_q.push_back('{addr: a, data: d, cyc: cyc});
         m_ok = sat_inc(m_ok);
         if (a == 8'd0) m_cfg = d;
      end else begin
         m_err = sat_inc(m_err);
      end
      check_model(tag);
   endtask

   // Write monitor: every pulse must match the oldest expected write and
   // appear exactly one cycle after the checksum strobe.
   initial begin
      forever begin
         @(negedge clk);
         if (cfg_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got addr=%h data=%h, expected no write (t=%0t)",
                        cfg_wr_addr, cfg_wr_data, $time);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               check("wr_addr",    32'(cfg_wr_addr), 32'(e.addr));
               check("wr_data",    cfg_wr_data,      e.data);
               check("wr_latency", cyc,              e.cyc);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  a;
      logic [7:0]  cs;
      logic [7:0]  junk;
      logic [31:0] d;

      rst        = 1'b1;
      byte_valid = 1'b0;
      byte_in    = 8'h00;
      gap(3);
      check("rst_wr_en",   32'(cfg_wr_en),   32'd0);
      check("rst_wr_addr", 32'(cfg_wr_addr), 32'd0);
      check("rst_wr_data", cfg_wr_data,      32'd0);
      check_model("rst");
      rst = 1'b0;
      gap(2);

      // Directed packets.
      send_pkt(8'h00, 32'h1234_5678, 8'h08, 0, -1, 0, "good_reg0");
      send_pkt(8'h02, 32'hDEAD_BEEF, 8'h20, 0, -1, 0, "good_reg2");
      send_pkt(8'h00, 32'h1234_5678, 8'h09, 0, -1, 0, "bad_csum");
      send_pkt(8'h04, 32'h0000_0000, 8'h04, 0, -1, 0, "bad_addr");
      check("hold_wr_addr", 32'(cfg_wr_addr), 32'h02);
      check("hold_wr_data", cfg_wr_data,      32'hDEAD_BEEF);

      // Timeout: a gap of exactly TIMEOUT idle cycles aborts the packet.
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h12);
      gap(TIMEOUT - 1);
      check("timeout_busy_before", 32'(busy), 32'd1);
      gap(1);
      m_err = sat_inc(m_err);
      check_model("timeout");
      send_pkt(8'h00, 32'hCAFE_F00D, xor_sum(8'h00, 32'hCAFE_F00D), 0, -1, 0,
               "after_timeout");
      // One cycle shorter: the byte wins and the packet completes.
      send_pkt(8'h00, 32'h1234_5678, 8'h08, 0, 4, TIMEOUT - 1, "long_gap");

      // Randomised traffic with inter-packet junk.
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 2) == 0) begin
            junk = 8'($urandom);
            if (junk == 8'hA5) junk = 8'h5A;
            send_byte(junk);
         end
         a  = 8'($urandom_range(0, 5));
         d  = $urandom;
         cs = xor_sum(a, d);
         if ($urandom_range(0, 3) == 0) cs = cs ^ (8'd1 << $urandom_range(0, 7));
         send_pkt(a, d, cs, 3, -1, 0, "random");
      end

      // Reset in the middle of a packet discards it.
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h12);
      send_byte(8'h34);
      rst = 1'b1;
      tick();
      rst   = 1'b0;
      m_ok  = 0;
      m_err = 0;
      m_cfg = CFG_RESET;
      check_model("mid_reset");
      send_pkt(8'h00, 32'hA5A5_A5A5, 8'h00, 0, -1, 0, "sync_in_data");

      // Error counter saturation.
      for (int n = 0; n < 300; n++) begin
         d = $urandom;
         send_pkt(8'h01, d, ~xor_sum(8'h01, d), 0, -1, 0, "saturate");
      end
      check("sat_err_count", 32'(pkt_err_count), 32'd255);

      gap(4);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_cfg_packet_parser
